ps2_key_matrix: RTL and testbench

- Self-contained PS/2 keyboard front end: synchronises ps2_clk/ps2_data, deserialises 11-bit frames, and checks odd parity, start and stop bits and inter-bit timeout.
- Decodes E0 (extended) and F0 (break) prefixes into complete scancode events.
- Keeps a held-state bitmap for N_KEYS parametrised keycodes, so several keys can be held at once, with one-cycle press/release pulses per key.
- Sits between the board PS/2 pins and game control logic; supersedes the single-key arrow/space/esc decoder.

---
 rtl/ps2_key_matrix_if.sv | 28 ++
 rtl/ps2_key_matrix.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_key_matrix.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_matrix_if.sv
// PS/2 key matrix bundle: keyboard pins in, key state and scancode events out.
// master = key matrix side, slave = game logic / keyboard model side.
interface ps2_key_matrix_if #(
  parameter int N_KEYS = 6
);
  logic              ps2_clk;
  logic              ps2_data;
  logic [N_KEYS-1:0] key_held;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic              code_valid;
  logic [7:0]        code;
  logic              code_ext;
  logic              code_break;
  logic              frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output key_held, key_press, key_release,
    output code_valid, code, code_ext, code_break, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  key_held, key_press, key_release,
    input  code_valid, code, code_ext, code_break, frame_err
  );
endinterface

// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard front end: sync, 11-bit frame rx, E0/F0 decode, held-key map.
// Ports: clk, rst (async, active-high), kb (ps2_key_matrix_if.master).
// Option: PS2_TYPEMATIC_EN makes repeated makes of a held key pulse key_press.
module ps2_key_matrix #(
  parameter int                  N_KEYS      = 6,
  parameter logic [8*N_KEYS-1:0] KEY_CODES   =
    {8'h76, 8'h29, 8'h72, 8'h75, 8'h74, 8'h6B},
  parameter int                  SYNC_STAGES = 2,
  parameter int                  TIMEOUT_CYC = 5000
) (
  input logic               clk,
  input logic               rst,
  ps2_key_matrix_if.master  kb
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_q;
  logic                   fall;
  logic                   bit_in;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic        byte_stb;
  logic        err;

  logic [N_KEYS-1:0] hit;
  logic [N_KEYS-1:0] held_q, held_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] rel_q, rel_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic        ev;
  logic        is_e0, is_f0, is_aa;
  logic        cv_q;
  logic [7:0]  code_q;
  logic        cext_q, cbrk_q;
  logic        ferr_q;

  // Synchronisers idle high so reset never fabricates a falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_q    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], kb.ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], kb.ps2_data};
      clk_q    <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_q & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    par_d    = par_q;
    tcnt_d   = tcnt_q + TW'(1);
    byte_stb = 1'b0;
    err      = 1'b0;
    if (state_q == IDLE) tcnt_d = '0;
    if (fall) begin
      tcnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          sh_d  = {bit_in, sh_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (bit_in && (^{sh_q, par_q})) byte_stb = 1'b1;
          else err = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE &&
                 tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      tcnt_d  = '0;
      err     = 1'b1;
    end
  end

  assign is_e0 = (sh_q == 8'hE0);
  assign is_f0 = (sh_q == 8'hF0);
  assign is_aa = (sh_q == 8'hAA);

  // Extended prefix is not part of the match; duplicates all fire
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_KEYS; i++)
      hit[i] = (KEY_CODES[8*i +: 8] == sh_q);
  end

  always_comb begin
    held_d  = held_q;
    press_d = '0;
    rel_d   = '0;
    ext_d   = ext_q;
    brk_d   = brk_q;
    ev      = 1'b0;
    if (err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
    if (byte_stb) begin
      unique case (1'b1)
        is_e0: ext_d = 1'b1;
        is_f0: brk_d = 1'b1;
        is_aa: begin
          held_d = '0;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
          ev     = 1'b1;
        end
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          ev    = 1'b1;
          if (brk_q) begin
            rel_d  = hit & held_q;
            held_d = held_q & ~hit;
          end else begin
`ifdef PS2_TYPEMATIC_EN
            press_d = hit;
`else
            press_d = hit & ~held_q;
`endif
            held_d  = held_q | hit;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      cv_q    <= 1'b0;
      code_q  <= '0;
      cext_q  <= 1'b0;
      cbrk_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      held_q  <= held_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      cv_q    <= ev;
      ferr_q  <= err;
      if (ev) begin
        code_q <= sh_q;
        cext_q <= ext_q;
        cbrk_q <= brk_q;
      end
    end
  end

  assign kb.key_held    = held_q;
  assign kb.key_press   = press_q;
  assign kb.key_release = rel_q;
  assign kb.code_valid  = cv_q;
  assign kb.code        = code_q;
  assign kb.code_ext    = cext_q;
  assign kb.code_break  = cbrk_q;
  assign kb.frame_err   = ferr_q;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: table of frames plus timeout,
// glitch and mid-frame reset sequences.
module tb_ps2_key_matrix;

  localparam int TO = 5000;
`ifdef PS2_TYPEMATIC_EN
  localparam logic TYP = 1'b1;
`else
  localparam logic TYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_matrix_if #(.N_KEYS(6)) bus ();

  ps2_key_matrix #(
    .N_KEYS(6),
    .KEY_CODES({8'h76, 8'h29, 8'h72, 8'h75, 8'h74, 8'h6B}),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kb(bus)
  );

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       bad_stop;
    int         cv;
    int         er;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [5:0] prs;
    logic [5:0] rel;
    logic [5:0] held;
  } vec_t;

  vec_t tv[21];
  int total = 0;
  int bad = 0;

  int cv_tot = 0;
  int er_tot = 0;
  int pc[6];
  int rc[6];

  initial begin
    for (int k = 0; k < 6; k++) begin
      pc[k] = 0;
      rc[k] = 0;
    end
  end

  always @(negedge clk) begin
    if (bus.code_valid) cv_tot++;
    if (bus.frame_err) er_tot++;
    for (int k = 0; k < 6; k++) begin
      if (bus.key_press[k]) pc[k]++;
      if (bus.key_release[k]) rc[k]++;
    end
  end

  task automatic check(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b,
                                     input logic bp, input logic bs);
    logic par;
    par = (~^b) ^ bp;
    return {~bs, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      bus.ps2_data = bits[k];
      repeat (12) @(posedge clk);
      #1 bus.ps2_clk = 1'b0;
      repeat (25) @(posedge clk);
      #1 bus.ps2_clk = 1'b1;
      repeat (13) @(posedge clk);
      #1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic apply(input int i);
    int cv0, er0, psum, rsum;
    int p0[6];
    int r0[6];
    logic [5:0] pv, rv;
    cv0 = cv_tot;
    er0 = er_tot;
    p0 = pc;
    r0 = rc;
    send_bits(mk(tv[i].b, tv[i].bad_par, tv[i].bad_stop), 11);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    psum = 0;
    rsum = 0;
    for (int k = 0; k < 6; k++) begin
      pv[k] = (pc[k] != p0[k]);
      rv[k] = (rc[k] != r0[k]);
      psum += pc[k] - p0[k];
      rsum += rc[k] - r0[k];
    end
    check("code_valid_cnt", i, cv_tot - cv0, tv[i].cv);
    check("frame_err_cnt", i, er_tot - er0, tv[i].er);
    check("code", i, {24'd0, bus.code}, {24'd0, tv[i].code});
    check("code_ext", i, {31'd0, bus.code_ext}, {31'd0, tv[i].ext});
    check("code_break", i, {31'd0, bus.code_break}, {31'd0, tv[i].brk});
    check("key_press", i, {26'd0, pv}, {26'd0, tv[i].prs});
    check("press_pulses", i, psum, $countones(tv[i].prs));
    check("key_release", i, {26'd0, rv}, {26'd0, tv[i].rel});
    check("release_pulses", i, rsum, $countones(tv[i].rel));
    check("key_held", i, {26'd0, bus.key_held}, {26'd0, tv[i].held});
  endtask

  initial begin
    int cv0, er0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;

    tv[0]  = '{8'h6B, 1'b0, 1'b0, 1, 0, 8'h6B, 1'b0, 1'b0, 6'b000001, 6'b0, 6'b000001};
    tv[1]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h6B, 1'b0, 1'b0, 6'b0, 6'b0, 6'b000001};
    tv[2]  = '{8'h75, 1'b0, 1'b0, 1, 0, 8'h75, 1'b1, 1'b0, 6'b000100, 6'b0, 6'b000101};
    tv[3]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h75, 1'b1, 1'b0, 6'b0, 6'b0, 6'b000101};
    tv[4]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h75, 1'b1, 1'b0, 6'b0, 6'b0, 6'b000101};
    tv[5]  = '{8'h75, 1'b0, 1'b0, 1, 0, 8'h75, 1'b1, 1'b1, 6'b0, 6'b000100, 6'b000001};
    tv[6]  = '{8'h74, 1'b0, 1'b0, 1, 0, 8'h74, 1'b0, 1'b0, 6'b000010, 6'b0, 6'b000011};
    tv[7]  = '{8'h29, 1'b0, 1'b0, 1, 0, 8'h29, 1'b0, 1'b0, 6'b010000, 6'b0, 6'b010011};
    tv[8]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h29, 1'b0, 1'b0, 6'b0, 6'b0, 6'b010011};
    tv[9]  = '{8'h74, 1'b0, 1'b0, 1, 0, 8'h74, 1'b0, 1'b1, 6'b0, 6'b000010, 6'b010001};
    tv[10] = '{8'h29, 1'b1, 1'b0, 0, 1, 8'h74, 1'b0, 1'b1, 6'b0, 6'b0, 6'b010001};
    tv[11] = '{8'h29, 1'b0, 1'b1, 0, 1, 8'h74, 1'b0, 1'b1, 6'b0, 6'b0, 6'b010001};
    tv[12] = '{8'h76, 1'b0, 1'b0, 1, 0, 8'h76, 1'b0, 1'b0, 6'b100000, 6'b0, 6'b110001};
    tv[13] = '{8'h76, 1'b0, 1'b0, 1, 0, 8'h76, 1'b0, 1'b0, {6{TYP}} & 6'b100000, 6'b0, 6'b110001};
    tv[14] = '{8'h76, 1'b0, 1'b0, 1, 0, 8'h76, 1'b0, 1'b0, {6{TYP}} & 6'b100000, 6'b0, 6'b110001};
    tv[15] = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0, 6'b0, 6'b0, 6'b110001};
    tv[16] = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0, 6'b0, 6'b0, 6'b110001};
    tv[17] = '{8'h29, 1'b1, 1'b0, 0, 1, 8'h1C, 1'b0, 1'b0, 6'b0, 6'b0, 6'b110001};
    tv[18] = '{8'h29, 1'b0, 1'b0, 1, 0, 8'h29, 1'b0, 1'b0, {6{TYP}} & 6'b010000, 6'b0, 6'b110001};
    tv[19] = '{8'h6B, 1'b0, 1'b0, 1, 0, 8'h6B, 1'b0, 1'b0, 6'b000001, 6'b0, 6'b000001};
    tv[20] = '{8'hAA, 1'b0, 1'b0, 1, 0, 8'hAA, 1'b0, 1'b0, 6'b0, 6'b0, 6'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_held", -1, {26'd0, bus.key_held}, 32'd0);
    check("rst_code", -1, {24'd0, bus.code}, 32'd0);
    check("rst_valid", -1, {31'd0, bus.code_valid}, 32'd0);
    check("rst_err", -1, {31'd0, bus.frame_err}, 32'd0);

    for (int i = 0; i <= 11; i++) apply(i);

    // data=1 on a fall while idle is ignored
    cv0 = cv_tot;
    er0 = er_tot;
    send_bits(11'h7FF, 1);
    repeat (10) @(posedge clk);
    check("glitch_err", 100, er_tot - er0, 0);
    check("glitch_valid", 100, cv_tot - cv0, 0);

    // truncated frame aborted by the inter-bit timeout
    cv0 = cv_tot;
    er0 = er_tot;
    send_bits(mk(8'h76, 1'b0, 1'b0), 4);
    repeat (TO + 20) @(posedge clk);
    @(negedge clk);
    check("timeout_err", 101, er_tot - er0, 1);
    check("timeout_valid", 101, cv_tot - cv0, 0);
    check("timeout_held", 101, {26'd0, bus.key_held}, {26'd0, 6'b010001});

    for (int i = 12; i <= 18; i++) apply(i);

    // asynchronous reset in the middle of a frame
    send_bits(mk(8'h6B, 1'b0, 1'b0), 5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_held", 102, {26'd0, bus.key_held}, 32'd0);
    check("midrst_code", 102, {24'd0, bus.code}, 32'd0);
    check("midrst_valid", 102, {31'd0, bus.code_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("postrst_held", 103, {26'd0, bus.key_held}, 32'd0);

    for (int i = 19; i <= 20; i++) apply(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
